// File: rtl/fan_tach.sv
// fan_tach: tachometer front-end for one fan.
//   Synchronizes and glitch-filters the raw tach line, counts filtered falling
//   edges per window of WIN_CNT+1 clocks, publishes the count with a one-cycle
//   valid pulse and raises a sticky stall flag after STALL_WIN empty windows.
//   Optional min/max tracking of published counts: define FAN_TACH_MINMAX_EN.
// Ports:
//   CLK_I     system clock
//   RST_I     synchronous active-high reset
//   FAN_IN    raw asynchronous tach input (idle high)
//   tach_clr  pulse: clears stall flag, zero-window count, min/max trackers
//   fan_cnt   edges counted in the last completed window (saturating)
//   fan_vld   one-cycle pulse when fan_cnt updates
//   win_tick  one-cycle pulse on the last cycle of each window
//   fan_stall sticky stall flag
//   fan_min   minimum fan_cnt since reset/clear (constant when feature is off)
//   fan_max   maximum fan_cnt since reset/clear (constant when feature is off)
module fan_tach #(
  parameter int unsigned WIN_CNT   = 49999999,
  parameter int unsigned FILT_LEN  = 16,
  parameter int unsigned STALL_WIN = 3
) (
  input  logic        CLK_I,
  input  logic        RST_I,
  input  logic        FAN_IN,
  input  logic        tach_clr,
  output logic [26:0] fan_cnt,
  output logic        fan_vld,
  output logic        win_tick,
  output logic        fan_stall,
  output logic [26:0] fan_min,
  output logic [26:0] fan_max
);

  localparam int unsigned      WIN_W     = (WIN_CNT < 1) ? 1 : $clog2(WIN_CNT + 1);
  localparam logic [WIN_W-1:0] WIN_LAST  = WIN_W'(WIN_CNT);
  localparam logic [7:0]       FILT_LAST = 8'(FILT_LEN - 1);
  localparam logic [3:0]       ZW_LAST   = 4'(STALL_WIN);
  localparam logic [26:0]      CNT_MAX   = 27'h7FF_FFFF;

  logic             r_sync1;
  logic             r_sync2;
  logic             r_filt;
  logic             r_filt_d;
  logic [7:0]       r_stab;
  logic [WIN_W-1:0] r_win;
  logic [26:0]      r_edge_cnt;
  logic [26:0]      r_cnt;
  logic             r_vld;
  logic [3:0]       r_zw;
  logic             r_stall;

  logic             w_edge;
  logic             w_tick;
  logic [26:0]      w_close_cnt;
  logic             w_zero_win;
  logic [3:0]       w_zw_next;
  logic             w_set;

  assign w_edge = r_filt_d & ~r_filt;
  assign w_tick = (r_win == WIN_LAST);

  // An edge landing on the closing cycle belongs to the closing window.
  assign w_close_cnt = (w_edge && (r_edge_cnt != CNT_MAX)) ? r_edge_cnt + 27'd1 : r_edge_cnt;
  assign w_zero_win  = (r_edge_cnt == 27'd0) && !w_edge;
  assign w_zw_next   = !w_zero_win ? 4'd0 :
                       (r_zw == ZW_LAST) ? ZW_LAST : r_zw + 4'd1;
  // Setting the stall flag has priority over a coincident clear.
  assign w_set       = w_tick && w_zero_win && (w_zw_next == ZW_LAST);

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      r_sync1    <= 1'b1;
      r_sync2    <= 1'b1;
      r_filt     <= 1'b1;
      r_filt_d   <= 1'b1;
      r_stab     <= '0;
      r_win      <= '0;
      r_edge_cnt <= '0;
      r_cnt      <= '0;
      r_vld      <= 1'b0;
      r_zw       <= '0;
      r_stall    <= 1'b0;
    end else begin
      r_sync1  <= FAN_IN;
      r_sync2  <= r_sync1;
      r_filt_d <= r_filt;

      // Level must disagree for FILT_LEN consecutive cycles to be accepted.
      if (r_sync2 != r_filt) begin
        if (r_stab == FILT_LAST) begin
          r_filt <= r_sync2;
          r_stab <= '0;
        end else begin
          r_stab <= r_stab + 8'd1;
        end
      end else begin
        r_stab <= '0;
      end

      r_win <= w_tick ? '0 : r_win + 1'b1;
      r_vld <= w_tick;

      if (w_tick) begin
        r_cnt      <= w_close_cnt;
        r_edge_cnt <= '0;
      end else if (w_edge && (r_edge_cnt != CNT_MAX)) begin
        r_edge_cnt <= r_edge_cnt + 27'd1;
      end

      if (w_set) begin
        r_stall <= 1'b1;
        r_zw    <= ZW_LAST;
      end else if (tach_clr) begin
        r_stall <= 1'b0;
        r_zw    <= '0;
      end else if (w_tick) begin
        r_zw <= w_zw_next;
      end
    end
  end

`ifdef FAN_TACH_MINMAX_EN
  logic [26:0] r_min;
  logic [26:0] r_max;

  // A clear coinciding with a window close seeds both trackers with the new count.
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      r_min <= CNT_MAX;
      r_max <= '0;
    end else if (w_tick) begin
      if (tach_clr) begin
        r_min <= w_close_cnt;
        r_max <= w_close_cnt;
      end else begin
        if (w_close_cnt < r_min) r_min <= w_close_cnt;
        if (w_close_cnt > r_max) r_max <= w_close_cnt;
      end
    end else if (tach_clr) begin
      r_min <= CNT_MAX;
      r_max <= '0;
    end
  end

  assign fan_min = r_min;
  assign fan_max = r_max;
`else
  assign fan_min = CNT_MAX;
  assign fan_max = '0;
`endif

  assign fan_cnt   = r_cnt;
  assign fan_vld   = r_vld;
  assign win_tick  = w_tick;
  assign fan_stall = r_stall;

endmodule

// File: tb/tb_fan_tach.sv
module tb_fan_tach;
  localparam int WIN     = 99;
  localparam int FL      = 4;
  localparam int SW      = 3;
  localparam int MAXV    = 134217727;
  // Last drive position whose falling edge is still counted in the same window.
  localparam int LAST_IN = WIN - FL - 2;

  logic        CLK_I = 1'b0;
  logic        RST_I;
  logic        FAN_IN;
  logic        tach_clr;
  logic [26:0] fan_cnt;
  logic        fan_vld;
  logic        win_tick;
  logic        fan_stall;
  logic [26:0] fan_min;
  logic [26:0] fan_max;

  fan_tach #(.WIN_CNT(WIN), .FILT_LEN(FL), .STALL_WIN(SW)) dut (
    .CLK_I(CLK_I), .RST_I(RST_I), .FAN_IN(FAN_IN), .tach_clr(tach_clr),
    .fan_cnt(fan_cnt), .fan_vld(fan_vld), .win_tick(win_tick),
    .fan_stall(fan_stall), .fan_min(fan_min), .fan_max(fan_max)
  );

  always #5 CLK_I = ~CLK_I;

  typedef struct {
    int cnt;
    int stall;
    int mn;
    int mx;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          n_checks = 0;
  int          n_fail   = 0;
  int          pos      = 0;
  bit          vld_due  = 1'b0;
  bit          mon_en   = 1'b0;
  int          low_left = 0;
  logic [99:0] prev_mask = '0;
  int          prev_len  = 0;
  int          m_zc = 0, m_stall = 0, m_mn = MAXV, m_mx = 0;

  task automatic step();
    @(posedge CLK_I);
    #1;
    vld_due = (pos == WIN) && !RST_I;
    if (RST_I) pos = 0;
    else       pos = (pos == WIN) ? 0 : pos + 1;
  endtask

  function automatic int pop_range(input logic [99:0] m, input int lo, input int hi);
    int c = 0;
    for (int i = lo; i <= hi; i++) if (m[i]) c++;
    return c;
  endfunction

  function automatic logic [99:0] periodic(input int period, input int offset, input int last);
    logic [99:0] m = '0;
    for (int i = offset; i <= last; i += period) m[i] = 1'b1;
    return m;
  endfunction

  // Reference model for one window: edge count, stall state and trackers.
  task automatic push_exp(input logic [99:0] mask, input int len, input int clr_pos);
    exp_t e;
    int   nz;
    bit   set;
    e.cnt = ((prev_len >= FL) ? pop_range(prev_mask, LAST_IN + 1, WIN) : 0) +
            ((len >= FL) ? pop_range(mask, 0, LAST_IN) : 0);
    if (clr_pos >= 0 && clr_pos < WIN) begin
      m_zc = 0;
      m_stall = 0;
    end
    nz  = (e.cnt == 0) ? ((m_zc >= SW) ? SW : m_zc + 1) : 0;
    set = (e.cnt == 0) && (nz == SW);
    if (set) begin
      m_zc = SW;
      m_stall = 1;
    end else if (clr_pos == WIN) begin
      m_zc = 0;
      m_stall = 0;
    end else begin
      m_zc = nz;
    end
    e.stall = m_stall;
`ifdef FAN_TACH_MINMAX_EN
    if (clr_pos >= 0) begin
      m_mn = e.cnt;
      m_mx = e.cnt;
    end else begin
      if (e.cnt < m_mn) m_mn = e.cnt;
      if (e.cnt > m_mx) m_mx = e.cnt;
    end
`else
    m_mn = MAXV;
    m_mx = 0;
`endif
    e.mn = m_mn;
    e.mx = m_mx;
    sb.push_back(e);
  endtask

  // Runs one full window starting at pos 0; lows of length len begin where mask is set.
  task automatic run_win(input logic [99:0] mask, input int len, input int clr_pos);
    int p;
    push_exp(mask, len, clr_pos);
    for (int i = 0; i <= WIN; i++) begin
      if (mask[pos]) low_left = len;
      FAN_IN = (low_left > 0) ? 1'b0 : 1'b1;
      if (low_left > 0) low_left--;
      tach_clr = (pos == clr_pos);
      p = pos;
      step();
      if (p == clr_pos && clr_pos < WIN) begin
        n_checks++;
        if (fan_stall !== 1'b0) begin
          n_fail++;
          $display("FAIL clr_stall: got %0b want 0", fan_stall);
        end
        n_checks++;
        if (fan_min !== 27'(MAXV) || fan_max !== 27'd0) begin
          n_fail++;
          $display("FAIL clr_minmax: got min=%0d max=%0d want min=%0d max=0", fan_min, fan_max, MAXV);
        end
      end
    end
    tach_clr  = 1'b0;
    prev_mask = mask;
    prev_len  = len;
  endtask

  always @(negedge CLK_I) begin
    if (mon_en) begin
      n_checks++;
      if (win_tick !== (pos == WIN)) begin
        n_fail++;
        $display("FAIL win_tick: pos=%0d got %0b want %0b", pos, win_tick, (pos == WIN));
      end
      n_checks++;
      if (fan_vld !== vld_due) begin
        n_fail++;
        $display("FAIL fan_vld: pos=%0d got %0b want %0b", pos, fan_vld, vld_due);
      end
      if (fan_vld === 1'b1) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL sb_empty: fan_vld with no expected window, fan_cnt=%0d", fan_cnt);
        end else begin
          mon_e = sb.pop_front();
          n_checks++;
          if (fan_cnt !== 27'(mon_e.cnt)) begin
            n_fail++;
            $display("FAIL fan_cnt: got %0d want %0d", fan_cnt, mon_e.cnt);
          end
          n_checks++;
          if (fan_stall !== 1'(mon_e.stall)) begin
            n_fail++;
            $display("FAIL fan_stall: got %0b want %0d", fan_stall, mon_e.stall);
          end
          n_checks++;
          if (fan_min !== 27'(mon_e.mn) || fan_max !== 27'(mon_e.mx)) begin
            n_fail++;
            $display("FAIL minmax: got min=%0d max=%0d want min=%0d max=%0d",
                     fan_min, fan_max, mon_e.mn, mon_e.mx);
          end
        end
      end
    end
  end

  task automatic test_reset();
    int n;
    RST_I = 1'b1;
    tach_clr = 1'b0;
    FAN_IN = 1'b0;
    for (int i = 0; i < 2; i++) begin
      FAN_IN = ~FAN_IN;
      step();
    end
    RST_I = 1'b0;
    FAN_IN = 1'b1;
    low_left = 0;
    prev_mask = '0;
    prev_len = 0;
    m_zc = 0; m_stall = 0; m_mn = MAXV; m_mx = 0;
    n_checks++;
    if (fan_cnt !== 27'd0 || fan_vld !== 1'b0 || fan_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_out: got cnt=%0d vld=%0b stall=%0b want 0 0 0", fan_cnt, fan_vld, fan_stall);
    end
    n_checks++;
    if (fan_min !== 27'(MAXV) || fan_max !== 27'd0) begin
      n_fail++;
      $display("FAIL reset_minmax: got min=%0d max=%0d want min=%0d max=0", fan_min, fan_max, MAXV);
    end
    mon_en = 1'b1;
    push_exp('0, 0, -1);
    n = 0;
    while (win_tick !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    n_checks++;
    if (n != WIN) begin
      n_fail++;
      $display("FAIL first_tick: cycles after reset got %0d want %0d", n + 1, WIN + 1);
    end
    step();
  endtask

  task automatic test_square();
    for (int w = 0; w < 3; w++) run_win(periodic(10, 5, 99), 5, -1);
  endtask

  task automatic test_glitch();
    for (int w = 0; w < 2; w++) run_win(periodic(20, 0, 99), 3, -1);
    for (int w = 0; w < 2; w++) run_win(periodic(20, 0, 99), 4, -1);
  endtask

  task automatic test_tick_edge();
    logic [99:0] m;
    m = '0;
    m[3] = 1'b1; m[18] = 1'b1; m[33] = 1'b1; m[48] = 1'b1; m[63] = 1'b1;
    m[LAST_IN] = 1'b1;
    run_win(m, 4, -1);
    m = '0;
    m[3] = 1'b1;
    run_win(m, 4, -1);
  endtask

  task automatic test_stall();
    for (int w = 0; w < 4; w++) run_win('0, 0, -1);
    run_win('0, 0, 50);
    run_win('0, 0, -1);
    run_win('0, 0, -1);
    run_win('0, 0, 50);
    run_win('0, 0, -1);
    run_win('0, 0, WIN);
    run_win('0, 0, -1);
  endtask

  task automatic test_minmax();
    logic [99:0] m;
    run_win(periodic(10, 5, 99), 5, -1);
    run_win(periodic(10, 5, 99), 5, 50);
    m = '0;
    m[10] = 1'b1; m[30] = 1'b1; m[50] = 1'b1; m[70] = 1'b1;
    run_win(m, 4, -1);
    run_win(periodic(12, 0, 84), 4, -1);
    run_win(periodic(12, 0, 72), 4, WIN);
    FAN_IN = 1'b1;
    step();
    step();
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: got %0d pending windows want 0", sb.size());
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_square();
    test_glitch();
    test_tick_edge();
    test_stall();
    test_minmax();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
